// File: rtl/game_pkg.sv
// Shared game definitions: player-unit opcodes, page encodings and the HP
// arbiter state type, plus a helper that packs an HP command word.
package game_pkg;

   localparam logic [3:0] HPY = 4'b0001;
   localparam logic [3:0] DPY = 4'b0010;
   localparam logic [3:0] IDG = 4'b0011;
   localparam logic [3:0] SDG = 4'b0100;
   localparam logic [3:0] MOV = 4'b0101;
   localparam logic [3:0] SHP = 4'b0110;

   localparam logic [3:0] TITLE  = 4'b0000;
   localparam logic [3:0] SELECT = 4'b0001;
   localparam logic [3:0] DODGE  = 4'b1001;
   localparam logic [3:0] OVER   = 4'b1111;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ISSUE,
      ARB_WAIT,
      ARB_COOL
   } arb_state_t;

   function automatic logic [15:0] make_hp_cmd(input logic is_heal, input logic [7:0] amt);
      return {(is_heal ? HPY : DPY), amt, 4'b0000};
   endfunction

endpackage

// File: rtl/hp_cmd_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping around, returned both one-hot and as an index.
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] idx
);
   logic [PW:0]  pos [N];
   logic [N-1:0] hit;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_off
         logic [PW:0] sum;
         assign sum     = {1'b0, ptr} + (PW+1)'(gi);
         assign pos[gi] = (sum >= (PW+1)'(N)) ? sum - (PW+1)'(N) : sum;
         assign hit[gi] = req[pos[gi][PW-1:0]];
      end
   endgenerate

   // Scan from the farthest offset down so the nearest hit is the last write.
   always_comb begin
      grant = '0;
      idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (hit[k]) idx = pos[k][PW-1:0];
      end
      if (|req) grant[idx] = 1'b1;
   end

endmodule

// File: rtl/hp_cmd_arbiter.sv
// Arbitrates heal/damage requests onto the player HP datapath, one command at a
// time, with a start/done handshake, a done timeout and post-damage invulnerability.
import game_pkg::*;

module hp_cmd_arbiter #(
   parameter int NREQ     = 4,
   parameter int COOLDOWN = 60,
   parameter int TIMEOUT  = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   heal,
   input  logic [8*NREQ-1:0] amount,
   output logic [NREQ-1:0]   ack,
   output logic [NREQ-1:0]   drop,
   output logic [15:0]       cmd,
   output logic              cmd_valid,
   input  logic              cmd_done,
   output logic              busy,
   output logic              timeout
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int CW = $clog2(COOLDOWN + 1);

   arb_state_t      state_reg;
   logic [PW-1:0]   ptr_reg;
   logic [TW-1:0]   timer_reg;
   logic [CW-1:0]   cool_reg;
   logic [15:0]     cmd_reg;
   logic            cmd_valid_reg;
   logic            timeout_reg;
   logic            is_dmg_reg;

   logic [NREQ-1:0] grant;
   logic [PW-1:0]   grant_idx;
   logic [PW-1:0]   ptr_next;
   logic [NREQ-1:0] dmg_req;
   logic [NREQ-1:0] ack_next;
   logic [NREQ-1:0] drop_next;
   logic [7:0]      amt_arr [NREQ];
   logic            grant_ok;
   logic            zero_dmg;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_src
         assign amt_arr[gi] = amount[8*gi +: 8];
         assign dmg_req[gi] = req[gi] & ~heal[gi];
      end
   endgenerate

   rr_pick #(.N(NREQ), .PW(PW)) u_pick (
      .req   (req),
      .ptr   (ptr_reg),
      .grant (grant),
      .idx   (grant_idx)
   );

   assign grant_ok = (state_reg == ARB_IDLE) && enable && (|req);
   assign zero_dmg = !heal[grant_idx] && (amt_arr[grant_idx] == 8'd0);
   assign ptr_next = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

   // ack/drop are combinational so a requester sees them in the grant cycle;
   // they are forced low while reset is held.
   always_comb begin
      ack_next  = '0;
      drop_next = '0;
      if (!rst) begin
         if (grant_ok) begin
            ack_next = grant;
            if (zero_dmg) drop_next = grant;
         end else if (state_reg == ARB_COOL) begin
            ack_next  = dmg_req;
            drop_next = dmg_req;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= ARB_IDLE;
         ptr_reg       <= '0;
         timer_reg     <= '0;
         cool_reg      <= '0;
         cmd_reg       <= '0;
         cmd_valid_reg <= 1'b0;
         timeout_reg   <= 1'b0;
         is_dmg_reg    <= 1'b0;
      end else begin
         cmd_valid_reg <= 1'b0;
         timeout_reg   <= 1'b0;
         case (state_reg)
            ARB_IDLE: begin
               if (grant_ok) begin
                  ptr_reg <= ptr_next;
                  if (!zero_dmg) begin
                     cmd_reg       <= make_hp_cmd(heal[grant_idx], amt_arr[grant_idx]);
                     is_dmg_reg    <= !heal[grant_idx];
                     cmd_valid_reg <= 1'b1;
                     state_reg     <= ARB_ISSUE;
                  end
               end
            end
            ARB_ISSUE: begin
               timer_reg <= '0;
               state_reg <= ARB_WAIT;
            end
            ARB_WAIT: begin
               // done takes priority over the timeout limit in the same cycle
               if (cmd_done) begin
                  cool_reg  <= '0;
                  state_reg <= is_dmg_reg ? ARB_COOL : ARB_IDLE;
               end else if (timer_reg == TW'(TIMEOUT - 1)) begin
                  timeout_reg <= 1'b1;
                  state_reg   <= ARB_IDLE;
               end else begin
                  timer_reg <= timer_reg + 1'b1;
               end
            end
            ARB_COOL: begin
               if (cool_reg == CW'(COOLDOWN - 1)) state_reg <= ARB_IDLE;
               else                               cool_reg  <= cool_reg + 1'b1;
            end
            default: state_reg <= ARB_IDLE;
         endcase
      end
   end

   assign ack       = ack_next;
   assign drop      = drop_next;
   assign cmd       = cmd_reg;
   assign cmd_valid = cmd_valid_reg;
   assign busy      = (state_reg != ARB_IDLE);
   assign timeout   = timeout_reg;

endmodule

// File: tb/tb_hp_cmd_arbiter.sv
// Randomized bench for hp_cmd_arbiter: a timeline reference model queues the
// expected per-cycle output events, and a monitor pops and compares them.
module tb_hp_cmd_arbiter;
   localparam int NREQ     = 4;
   localparam int COOLDOWN = 60;
   localparam int TIMEOUT  = 255;
   localparam int NEVER    = 32'h7fffffff;

   logic              clk = 1'b0;
   logic              rst;
   logic              enable;
   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   heal;
   logic [8*NREQ-1:0] amount;
   logic [NREQ-1:0]   ack;
   logic [NREQ-1:0]   drop;
   logic [15:0]       cmd;
   logic              cmd_valid;
   logic              cmd_done;
   logic              busy;
   logic              timeout;

   hp_cmd_arbiter #(.NREQ(NREQ), .COOLDOWN(COOLDOWN), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .req       (req),
      .heal      (heal),
      .amount    (amount),
      .ack       (ack),
      .drop      (drop),
      .cmd       (cmd),
      .cmd_valid (cmd_valid),
      .cmd_done  (cmd_done),
      .busy      (busy),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int              cyc;
      logic [NREQ-1:0] ack;
      logic [NREQ-1:0] drop;
      logic            cv;
      logic [15:0]     cmd;
      logic            to;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   done_at = -1;
   logic [NREQ-1:0] ack_last;
   logic            cv_last;
   bit              rst_done;

   // Reference model state, expressed as cycle-number windows.
   int          m_ptr, m_wstart, m_free, m_clo, m_chi;
   bit          m_wait, m_dmg, m_pcv, m_pto;
   logic [15:0] m_cmd;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_ack"},       32'(ack),       32'd0);
      chk({tag, "_drop"},      32'(drop),      32'd0);
      chk({tag, "_cmd"},       32'(cmd),       32'd0);
      chk({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
      chk({tag, "_busy"},      32'(busy),      32'd0);
      chk({tag, "_timeout"},   32'(timeout),   32'd0);
   endtask

   task automatic model_loop();
      exp_t e;
      logic [NREQ-1:0] a, d;
      logic [7:0] amt;
      bit cv_n, to_n;
      int w;
      forever begin
         @(negedge clk);
         if (rst) begin
            m_ptr = 0; m_wait = 0; m_free = 0; m_clo = 1; m_chi = 0;
            m_pcv = 0; m_pto = 0; m_dmg = 0; m_cmd = '0;
         end else begin
            a = '0; d = '0; cv_n = 0; to_n = 0;
            if (m_wait && cyc >= m_wstart) begin
               if (cmd_done) begin
                  m_wait = 0;
                  if (m_dmg) begin
                     m_clo = cyc + 1; m_chi = cyc + COOLDOWN; m_free = cyc + COOLDOWN + 1;
                  end else begin
                     m_free = cyc + 1;
                  end
               end else if (cyc - m_wstart == TIMEOUT - 1) begin
                  m_wait = 0; m_free = cyc + 1; to_n = 1;
               end
            end else if (!m_wait && cyc >= m_clo && cyc <= m_chi) begin
               a = req & ~heal;
               d = a;
            end else if (!m_wait && cyc >= m_free && enable && req != '0) begin
               w = -1;
               for (int k = 0; k < NREQ; k++)
                  if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
               a[w]  = 1'b1;
               m_ptr = (w + 1) % NREQ;
               amt   = amount[w*8 +: 8];
               if (!heal[w] && amt == 8'd0) begin
                  d[w] = 1'b1;
               end else begin
                  cv_n = 1; m_dmg = !heal[w]; m_wait = 1;
                  m_cmd = {(heal[w] ? 4'h1 : 4'h2), amt, 4'h0};
                  m_wstart = cyc + 2; m_free = NEVER;
               end
            end
            if (a != '0 || m_pcv || m_pto) begin
               e.cyc = cyc; e.ack = a; e.drop = d; e.cv = m_pcv; e.cmd = m_cmd; e.to = m_pto;
               exp_q.push_back(e);
            end
            m_pcv = cv_n;
            m_pto = to_n;
         end
      end
   endtask

   task automatic monitor_loop();
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            checks++; errors++;
            $display("FAIL missing_event: cyc=%0d got no output, expected ack=%b drop=%b cv=%b cmd=%h to=%b",
                     e.cyc, e.ack, e.drop, e.cv, e.cmd, e.to);
         end
         if (!rst && (ack != '0 || drop != '0 || cmd_valid || timeout)) begin
            checks++;
            if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
               errors++;
               $display("FAIL unexpected_event: cyc=%0d got ack=%b drop=%b cv=%b cmd=%h to=%b, expected none",
                        cyc, ack, drop, cmd_valid, cmd, timeout);
            end else begin
               e = exp_q.pop_front();
               if (ack !== e.ack || drop !== e.drop || cmd_valid !== e.cv || timeout !== e.to ||
                   (e.cv && cmd !== e.cmd)) begin
                  errors++;
                  $display("FAIL event: cyc=%0d got ack=%b drop=%b cv=%b cmd=%h to=%b expected ack=%b drop=%b cv=%b cmd=%h to=%b",
                           cyc, ack, drop, cmd_valid, cmd, timeout, e.ack, e.drop, e.cv, e.cmd, e.to);
               end else begin
                  $display("txn cyc=%0d ack=%b drop=%b cv=%b cmd=%h to=%b", cyc, ack, drop, cmd_valid, cmd, timeout);
               end
            end
         end
      end
   endtask

   // Player unit: answers each start pulse after 0..4 cycles, occasionally never.
   task automatic player_loop();
      forever begin
         @(negedge clk);
         if (rst) done_at = -1;
         else if (cmd_valid)
            done_at = ($urandom_range(0, 11) == 0) ? -1 : cyc + 1 + int'($urandom_range(0, 4));
      end
   endtask

   task automatic drive(input bit allow_new);
      for (int i = 0; i < NREQ; i++) begin
         if (req[i] && ack_last[i]) begin
            req[i] = 1'b0;
         end else if (!req[i] && allow_new && $urandom_range(0, 5) == 0) begin
            req[i]  = 1'b1;
            heal[i] = 1'($urandom_range(0, 1));
            amount[i*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         end
      end
      if (!allow_new) enable = 1'b1;
      else if ($urandom_range(0, 24) == 0) enable = ~enable;
      cmd_done = (cyc == done_at);
   endtask

   initial begin
      rst = 1'b0; enable = 1'b0; req = '0; heal = '0; amount = '0; cmd_done = 1'b0;
      ack_last = '0; cv_last = 1'b0; rst_done = 0;
      fork
         model_loop();
         monitor_loop();
         player_loop();
      join_none
      #1 rst = 1'b1;
      #1 check_reset("reset");
      repeat (3) @(posedge clk);
      #1 rst = 1'b0; enable = 1'b1;

      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         ack_last = ack;
         cv_last  = cmd_valid;
         @(posedge clk);
         if (k >= 1500 && !rst_done && cv_last) begin
            // first WAIT cycle of a command: hit it with an asynchronous reset
            #3;
            cmd_done = 1'b0;
            rst = 1'b1;
            #1 check_reset("async_rst");
            rst_done = 1;
            ack_last = '0;
            @(posedge clk);
            @(posedge clk);
            #1 rst = 1'b0;
         end else begin
            #1 drive(1'b1);
         end
      end
      checks++;
      if (!rst_done) begin
         errors++;
         $display("FAIL async_rst_window: got no command start after cycle budget, required one");
      end

      for (int k = 0; k < 1500; k++) begin
         @(negedge clk);
         ack_last = ack;
         @(posedge clk);
         #1 drive(1'b0);
      end
      repeat (2) @(negedge clk);
      #2;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
